// File: rtl/xor_encrypt_tx_if.sv
// Byte stream link (data/last with valid/ready) used on both sides of xor_encrypt_tx.
interface xor_encrypt_tx_if;
  logic [7:0] data;
  logic       valid;
  logic       last;
  logic       ready;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/xor_encrypt_tx.sv
// XOR stream encryptor: plaintext bytes XORed with a rotating 4-byte key into an output FIFO.
// Define CHECKSUM_EN to append an encrypted XOR checksum byte after each frame's last byte.
module xor_encrypt_tx #(
  parameter logic [31:0] KEY        = 32'hDEADBEEF,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  xor_encrypt_tx_if.slave         in_s,
  xor_encrypt_tx_if.master        out_m,
  input  logic                    key_sync,
  output logic [1:0]              key_index,
  output logic                    busy
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [8:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic [7:0]       push_data;
  logic             push_last;
  logic [1:0]       key_cur;

  function automatic logic [7:0] key_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    return KEY[31:24];
      2'd1:    return KEY[23:16];
      2'd2:    return KEY[15:8];
      default: return KEY[7:0];
    endcase
  endfunction

  assign full    = (count == CNT_W'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign key_cur = key_sync ? 2'd0 : key_index;
  assign pop     = !empty && out_m.ready;

  // Idle output reads as zero rather than exposing a stale FIFO slot.
  assign out_m.valid = !empty;
  assign out_m.data  = empty ? 8'h00 : mem[rd_ptr][7:0];
  assign out_m.last  = !empty && mem[rd_ptr][8];

`ifdef CHECKSUM_EN
  typedef enum logic {STREAM, CSUM} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] acc;

  assign in_s.ready = rst_n && !full && (state == STREAM);
  assign busy       = !empty || (state == CSUM);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= STREAM;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    push       = 1'b0;
    push_data  = in_s.data ^ key_byte(key_cur);
    push_last  = 1'b0;
    case (state)
      STREAM: begin
        if (in_s.valid && in_s.ready) begin
          push = 1'b1;
          if (in_s.last) state_next = CSUM;
        end
      end
      CSUM: begin
        if (!full) begin
          push       = 1'b1;
          push_data  = acc ^ key_byte(key_cur);
          push_last  = 1'b1;
          state_next = STREAM;
        end
      end
      default: state_next = STREAM;
    endcase
  end

  // acc already includes the frame's last byte by the time CSUM emits it.
  always_ff @(posedge clk) begin
    if (!rst_n)                        acc <= 8'h00;
    else if (state == CSUM && push)    acc <= 8'h00;
    else if (state == STREAM && push)  acc <= acc ^ in_s.data;
  end
`else
  assign in_s.ready = rst_n && !full;
  assign busy       = !empty;

  always_comb begin
    push      = in_s.valid && in_s.ready;
    push_data = in_s.data ^ key_byte(key_cur);
    push_last = in_s.last;
  end
`endif

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {push_last, push_data};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      key_index <= 2'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
      if (push)          key_index <= key_cur + 2'd1;
      else if (key_sync) key_index <= 2'd0;
    end
  end

endmodule

// File: tb/tb_xor_encrypt_tx.sv
// Self-checking bench for xor_encrypt_tx: queue-based reference model checked every cycle,
// plus literal expectations for the directed scenarios.
module tb_xor_encrypt_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_sync = 1'b0;
  logic [1:0] key_index;
  logic       busy;

  xor_encrypt_tx_if in_if();
  xor_encrypt_tx_if out_if();

  xor_encrypt_tx #(.KEY(32'hDEADBEEF), .FIFO_DEPTH(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_s      (in_if),
    .out_m     (out_if),
    .key_sync  (key_sync),
    .key_index (key_index),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0] key_bytes [4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
  logic [8:0] model_q [$];
  logic [8:0] seen [$];
  int         model_k = 0;
  logic [7:0] model_acc = 8'h00;
  bit         model_pend = 1'b0;

  bit         m_full;
  bit         m_ready;
  bit         m_push;
  int         m_kcur;
  logic [8:0] m_val;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference model: what the ciphertext stream must be, advanced once per clock.
  always @(negedge clk) begin
    m_full  = (model_q.size() == 4);
    m_ready = rst_n && !m_full && !model_pend;
    check_output("in_ready", in_if.ready, m_ready);
    check_output("out_valid", out_if.valid, model_q.size() != 0);
    check_output("busy", busy, (model_q.size() != 0) || model_pend);
    check_output("key_index", key_index, model_k);
    if (model_q.size() != 0) begin
      check_output("out_data", out_if.data, model_q[0][7:0]);
      check_output("out_last", out_if.last, model_q[0][8]);
    end

    if (rst_n && out_if.valid && out_if.ready) seen.push_back({out_if.last, out_if.data});

    if (!rst_n) begin
      model_q.delete();
      model_k    = 0;
      model_acc  = 8'h00;
      model_pend = 1'b0;
    end else begin
      m_kcur = key_sync ? 0 : model_k;
      m_push = 1'b0;
      m_val  = '0;
      if (model_pend) begin
        if (!m_full) begin
          m_val      = {1'b1, model_acc ^ key_bytes[m_kcur]};
          m_push     = 1'b1;
          model_acc  = 8'h00;
          model_pend = 1'b0;
        end
      end else if (in_if.valid && m_ready) begin
        m_push = 1'b1;
`ifdef CHECKSUM_EN
        m_val     = {1'b0, in_if.data ^ key_bytes[m_kcur]};
        model_acc = model_acc ^ in_if.data;
        if (in_if.last) model_pend = 1'b1;
`else
        m_val = {in_if.last, in_if.data ^ key_bytes[m_kcur]};
`endif
      end
      if (out_if.ready && model_q.size() != 0) void'(model_q.pop_front());
      if (m_push) begin
        model_q.push_back(m_val);
        model_k = (m_kcur + 1) % 4;
      end else if (key_sync) begin
        model_k = 0;
      end
    end
  end

  task automatic do_reset();
    rst_n        = 1'b0;
    in_if.valid  = 1'b0;
    in_if.last   = 1'b0;
    key_sync     = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    seen.delete();
  endtask

  task automatic apply_stimulus(input logic [7:0] d, input logic l, input logic s);
    bit ok = 1'b0;
    in_if.data  = d;
    in_if.last  = l;
    in_if.valid = 1'b1;
    key_sync    = s;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_if.ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("[TB] FAIL accept_timeout: got in_ready=0 for 200 cycles, expected acceptance");
    end
    @(posedge clk);
    #1;
    in_if.valid = 1'b0;
    in_if.last  = 1'b0;
    key_sync    = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (!out_if.valid && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      $display("[TB] FAIL drain_timeout: got busy=%0b out_valid=%0b, expected idle", busy, out_if.valid);
    end
    @(posedge clk);
    #1;
  endtask

  logic [7:0] exp1 [5] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'hDE};
  logic [7:0] pt2  [6] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
  logic [7:0] exp2 [6] = '{8'hCF, 8'h8F, 8'h8D, 8'hAB, 8'h8B, 8'hCB};
  logic [7:0] exp3 [4] = '{8'hDE, 8'hAD, 8'hDE, 8'hAD};

  initial begin
    in_if.data   = 8'h00;
    in_if.valid  = 1'b0;
    in_if.last   = 1'b0;
    out_if.ready = 1'b1;

    do_reset();
    @(negedge clk);
    check_output("rst_out_valid", out_if.valid, 0);
    check_output("rst_out_data", out_if.data, 0);
    check_output("rst_out_last", out_if.last, 0);
    check_output("rst_busy", busy, 0);
    check_output("rst_key_index", key_index, 0);
    @(posedge clk);
    #1;

    // Zero plaintext exposes the key rotation directly.
    for (int i = 0; i < 5; i++) apply_stimulus(8'h00, 1'b0, 1'b0);
    drain();
    check_output("s1_count", seen.size(), 5);
    for (int i = 0; i < 5; i++) check_output($sformatf("s1_byte%0d", i), seen[i], {1'b0, exp1[i]});
    check_output("s1_key_index", key_index, 1);

    // Backpressure: FIFO fills after 4, head must hold until released.
    do_reset();
    out_if.ready = 1'b0;
    for (int i = 0; i < 4; i++) apply_stimulus(pt2[i], 1'b0, 1'b0);
    in_if.data  = pt2[4];
    in_if.valid = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check_output("s2_full_ready", in_if.ready, 0);
      check_output("s2_hold_data", out_if.data, 8'hCF);
    end
    @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    apply_stimulus(pt2[4], 1'b0, 1'b0);
    apply_stimulus(pt2[5], 1'b0, 1'b0);
    drain();
    check_output("s2_count", seen.size(), 6);
    for (int i = 0; i < 6; i++) check_output($sformatf("s2_byte%0d", i), seen[i], {1'b0, exp2[i]});

    // key_sync realigns the key for the byte encrypted in the same cycle.
    do_reset();
    apply_stimulus(8'h00, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    apply_stimulus(8'h00, 1'b0, 1'b1);
    apply_stimulus(8'h00, 1'b0, 1'b0);
    drain();
    check_output("s3_count", seen.size(), 4);
    for (int i = 0; i < 4; i++) check_output($sformatf("s3_byte%0d", i), seen[i], {1'b0, exp3[i]});
    check_output("s3_key_index", key_index, 2);

    // Frame end: checksum byte appended only in the CHECKSUM_EN build.
    do_reset();
    apply_stimulus(8'h01, 1'b0, 1'b0);
    apply_stimulus(8'h02, 1'b1, 1'b0);
    @(negedge clk);
`ifdef CHECKSUM_EN
    check_output("s4_csum_ready", in_if.ready, 0);
`else
    check_output("s5_ready", in_if.ready, 1);
`endif
    @(negedge clk);
    check_output("s4_ready_back", in_if.ready, 1);
    @(posedge clk);
    #1;
    drain();
`ifdef CHECKSUM_EN
    check_output("s4_count", seen.size(), 3);
    check_output("s4_byte0", seen[0], {1'b0, 8'hDF});
    check_output("s4_byte1", seen[1], {1'b0, 8'hAF});
    check_output("s4_csum", seen[2], {1'b1, 8'hBD});
    check_output("s4_key_index", key_index, 3);
`else
    check_output("s5_count", seen.size(), 2);
    check_output("s5_byte0", seen[0], {1'b0, 8'hDF});
    check_output("s5_byte1", seen[1], {1'b1, 8'hAF});
    check_output("s5_key_index", key_index, 2);
`endif

    // Reset with bytes queued drops them and restarts the key.
    do_reset();
    out_if.ready = 1'b0;
    for (int i = 0; i < 3; i++) apply_stimulus(8'h00, 1'b0, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_output("s6_out_valid", out_if.valid, 0);
    check_output("s6_key_index", key_index, 0);
    check_output("s6_out_data", out_if.data, 0);
    check_output("s6_busy", busy, 0);
    @(posedge clk);
    #1;
    out_if.ready = 1'b1;
    seen.delete();
    apply_stimulus(8'h00, 1'b0, 1'b0);
    drain();
    check_output("s6_count", seen.size(), 1);
    check_output("s6_byte0", seen[0], {1'b0, 8'hDE});

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
